loteria_arbiter: RTL

Round-robin arbiter and sequencer sharing one `Jogo` lottery unit between `NPLAYERS` player terminals. It grants the unit to one terminal at a time and clears the unit before each session. It forwards the player's five digit inserts, issues `finish`, waits for the verdict, and returns the win/prize result to the owning terminal. It sits between the terminal inputs (switches/keys per player) and the single game instance.

---
 rtl/loteria_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/loteria_arbiter.sv
// rtl/loteria_arbiter.sv - round-robin arbiter sharing one Jogo unit between NPLAYERS terminals
// Optional FEED idle timeout guarded by LOTERIA_TIMEOUT_EN.
module loteria_arbiter #(
  parameter int NPLAYERS    = 4,
  parameter int RESULT_WAIT = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPLAYERS-1:0]     req,
  input  logic [4*NPLAYERS-1:0]   num_in,
  input  logic [NPLAYERS-1:0]     insert_in,
  output logic [NPLAYERS-1:0]     gnt,
  output logic [3:0]              game_num,
  output logic                    game_insert,
  output logic                    game_finish,
  output logic                    game_reset,
  input  logic                    game_win,
  input  logic [1:0]              game_prize,
  output logic [NPLAYERS-1:0]     done,
  output logic                    win_out,
  output logic [1:0]              prize_out,
  output logic                    abort,
  output logic                    busy
);

  localparam int IW = $clog2(NPLAYERS);
  localparam int WW = $clog2(RESULT_WAIT + 1);

  if (NPLAYERS < 2 || NPLAYERS > 8 || RESULT_WAIT < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("loteria_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FINISH, S_WAIT, S_REPORT
  } state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         owner, last, pick;
  logic                  pick_valid;
  logic [NPLAYERS-1:0]   owner_oh;
  logic [2:0]            dcnt;
  logic [WW-1:0]         wcnt;
  logic                  accept;
  logic                  timed_out;

  // Search starts just after the previous owner so a steady requester cannot starve others.
  always_comb begin
    pick       = last;
    pick_valid = 1'b0;
    for (int k = 1; k <= NPLAYERS; k++) begin
      if (!pick_valid && req[IW'((int'(last) + k) % NPLAYERS)]) begin
        pick_valid = 1'b1;
        pick       = IW'((int'(last) + k) % NPLAYERS);
      end
    end
  end

  assign owner_oh = {{(NPLAYERS-1){1'b0}}, 1'b1} << owner;
  assign accept   = (state == S_FEED) && (dcnt != 3'd5) && insert_in[owner];

`ifdef LOTERIA_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TW-1:0] icnt;
  logic          aborted;

  assign timed_out = (state == S_FEED) && (dcnt != 3'd5) && !accept && (icnt == TW'(TIMEOUT));
  assign abort     = (state == S_REPORT) && aborted;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      icnt    <= '0;
      aborted <= 1'b0;
    end else begin
      if (state != S_FEED || accept)
        icnt <= '0;
      else if (icnt != TW'(TIMEOUT))
        icnt <= icnt + 1'b1;
      if (state == S_CLEAR)
        aborted <= 1'b0;
      else if (timed_out)
        aborted <= 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
  assign abort     = 1'b0;
`endif

  always_comb begin
    state_nx    = state;
    gnt         = '0;
    game_finish = 1'b0;
    game_reset  = 1'b0;
    done        = '0;
    win_out     = 1'b0;
    prize_out   = 2'd0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pick_valid) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        gnt        = owner_oh;
        game_reset = 1'b1;
        state_nx   = S_FEED;
      end
      S_FEED: begin
        gnt = owner_oh;
        if (dcnt == 3'd5) begin
          state_nx = S_FINISH;
        end else if (timed_out) begin
          game_reset = 1'b1;
          state_nx   = S_REPORT;
        end
      end
      S_FINISH: begin
        gnt         = owner_oh;
        game_finish = 1'b1;
        state_nx    = S_WAIT;
      end
      S_WAIT: begin
        gnt = owner_oh;
        if (wcnt == WW'(RESULT_WAIT - 1)) state_nx = S_REPORT;
      end
      S_REPORT: begin
        gnt       = owner_oh;
        done      = owner_oh;
        win_out   = game_win & ~abort;
        prize_out = abort ? 2'd0 : game_prize;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      owner       <= '0;
      last        <= IW'(NPLAYERS - 1);
      dcnt        <= 3'd0;
      wcnt        <= '0;
      game_num    <= 4'd0;
      game_insert <= 1'b0;
    end else begin
      state       <= state_nx;
      game_insert <= accept;
      game_num    <= accept ? num_in[{owner, 2'b00} +: 4] : 4'd0;
      if (state == S_IDLE && pick_valid) begin
        owner <= pick;
        last  <= pick;
      end
      if (state == S_CLEAR)
        dcnt <= 3'd0;
      else if (accept)
        dcnt <= dcnt + 3'd1;
      if (state == S_WAIT)
        wcnt <= wcnt + 1'b1;
      else
        wcnt <= '0;
    end
  end

endmodule
